// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO-to-stream reader.
package fifo_reader_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    function automatic logic [1:0] state_occupancy(input state_e st);
        logic [1:0] occ;
        case (st)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream through
// a head/skid buffer, counting words delivered since reset or flush.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   fifo_empty,
    output logic                   fifo_r_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rdata,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [COUNT_WIDTH-1:0] rd_count
);

    state_e                 state_q,    state_d;
    logic [DATA_WIDTH-1:0]  head_q,     head_d;
    logic [DATA_WIDTH-1:0]  skid_q,     skid_d;
    logic                   inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0] rd_count_q, rd_count_d;

    logic                   pop_s;
    logic                   load_s;
    logic [2:0]             demand_s;
    logic [2:0]             limit_s;

    assign pop_s    = m_valid & m_ready;
    assign load_s   = inflight_q;
    assign m_valid  = (state_q != EMPTY);
    assign m_data   = head_q;
    assign rd_count = rd_count_q;

    // Issue a read only if the word can land in the buffer, counting this cycle's pop.
    always_comb begin
        demand_s  = {1'b0, state_occupancy(state_q)} + {2'b00, inflight_q};
        limit_s   = 3'(BUF_DEPTH) + {2'b00, pop_s};
        fifo_r_en = ~fifo_empty & ~flush & ~rst & (demand_s < limit_s);
    end

    // Buffer FSM: head always presents the oldest word, skid holds the next one.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load_s) begin
                        state_d = ONE;
                        head_d  = fifo_rdata;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (load_s && !pop_s) begin
                        state_d = TWO;
                        skid_d  = fifo_rdata;
                    end else if (pop_s && !load_s) begin
                        state_d = EMPTY;
                    end else if (load_s && pop_s) begin
                        state_d = ONE;
                        head_d  = fifo_rdata;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        head_d = skid_q;
                        if (load_s) begin
                            state_d = TWO;
                            skid_d  = fifo_rdata;
                        end else begin
                            state_d = ONE;
                        end
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // In-flight tracking and delivered-word counter; flush wins over a same-cycle pop.
    always_comb begin
        inflight_d = fifo_r_en;
        if (flush) begin
            rd_count_d = {COUNT_WIDTH{1'b0}};
        end else if (pop_s) begin
            rd_count_d = rd_count_q + COUNT_WIDTH'(1);
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= {DATA_WIDTH{1'b0}};
            skid_q     <= {DATA_WIDTH{1'b0}};
            inflight_q <= 1'b0;
            rd_count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    a_no_overflow_in_two : assert property (@(posedge clk) disable iff (rst)
        !((state_q == TWO) && load_s && !pop_s));

    a_no_read_when_empty : assert property (@(posedge clk)
        !(fifo_r_en && fifo_empty));

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus randomized
// traffic against a queue-based model of the FIFO and the delivered stream.
module tb_fifo_reader;

    localparam int DW   = 8;
    localparam int MEMD = 4096;

    logic          clk = 1'b0;
    logic          rst, flush, m_ready, gate_empty;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_r_en, m_valid;
    logic [DW-1:0] m_data;
    logic [7:0]    rd_count;
    logic          fifo_r_en2, m_valid2;
    logic [DW-1:0] m_data2;
    logic [1:0]    rd_count2;

    logic [DW-1:0] mem [MEMD];
    int unsigned   wr_ptr;
    int unsigned   rd_ptr;

    int            n_cmp = 0;
    int            n_err = 0;

    logic [DW-1:0] exp_q [$];
    int unsigned   mcount;
    logic          ev_pop, ev_pop2, ev_ren, ev_ren2, ev_empty, ev_clr, ev_valid, ev_have_exp;
    logic [DW-1:0] ev_data, ev_data2, ev_exp;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_r_en(fifo_r_en), .fifo_rdata(fifo_rdata), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count)
    );

    fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_r_en(fifo_r_en2), .fifo_rdata(fifo_rdata), .m_valid(m_valid2),
        .m_ready(m_ready), .m_data(m_data2), .rd_count(rd_count2)
    );

    // Synchronous FIFO model with one cycle of read latency.
    assign fifo_empty = (rd_ptr >= wr_ptr) || gate_empty;

    always @(posedge clk) begin
        if (fifo_r_en) begin
            fifo_rdata <= mem[rd_ptr % MEMD];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr % MEMD] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Observe the cycle just before the edge, advance the stream model, step one clock.
    task automatic tick();
        @(negedge clk);
        ev_valid    = m_valid;
        ev_pop      = m_valid && m_ready;
        ev_pop2     = m_valid2 && m_ready;
        ev_data     = m_data;
        ev_data2    = m_data2;
        ev_ren      = fifo_r_en;
        ev_ren2     = fifo_r_en2;
        ev_empty    = fifo_empty;
        ev_clr      = flush || rst;
        ev_have_exp = 1'b0;
        ev_exp      = '0;
        if (ev_pop) begin
            if (exp_q.size() > 0) begin
                ev_exp      = exp_q.pop_front();
                ev_have_exp = 1'b1;
            end
            mcount = mcount + 1;
        end
        if (ev_clr) begin
            exp_q.delete();
            mcount = 0;
        end
        if (ev_ren) exp_q.push_back(mem[rd_ptr % MEMD]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; gate_empty = 1'b0;
        tick();
        tick();
        push(8'hA5);
        #1;
        n_cmp++; if (fifo_r_en !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b expected 0", fifo_r_en); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", m_data); end
        n_cmp++; if (rd_count !== 8'd0 || rd_count2 !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d/%0d expected 0/0", rd_count, rd_count2); end
        rst = 1'b0; m_ready = 1'b1;
        #1;
        n_cmp++; if (fifo_r_en !== 1'b1) begin n_err++; $display("FAIL release_ren: got %b expected 1", fifo_r_en); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL release_lat1: got valid %b expected 0", m_valid); end
        tick();
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin n_err++; $display("FAIL release_lat2: got %b/%h expected 1/a5", m_valid, m_data); end
        tick();
        n_cmp++; if (m_valid !== 1'b0 || rd_count !== 8'd1) begin n_err++; $display("FAIL release_done: got %b/%0d expected 0/1", m_valid, rd_count); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] w [3];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        do_flush();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(w[i]);
        #1;
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (fifo_r_en !== (k < 3)) begin n_err++; $display("FAIL basic_ren k=%0d: got %b expected %b", k, fifo_r_en, (k < 3)); end
            n_cmp++; if (m_valid !== (k >= 2 && k <= 4)) begin n_err++; $display("FAIL basic_valid k=%0d: got %b", k, m_valid); end
            if (k >= 2 && k <= 4) begin
                n_cmp++; if (m_data !== w[k-2]) begin n_err++; $display("FAIL basic_data k=%0d: got %h expected %h", k, m_data, w[k-2]); end
            end
            tick();
        end
        n_cmp++; if (rd_count !== 8'd3) begin n_err++; $display("FAIL basic_count: got %0d expected 3", rd_count); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] w [4];
        int n_rd;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(w[i]);
        n_rd = 0;
        repeat (6) begin
            tick();
            if (ev_ren) n_rd++;
        end
        n_cmp++; if (n_rd != 2) begin n_err++; $display("FAIL stall_reads: got %0d expected 2", n_rd); end
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin n_err++; $display("FAIL stall_hold: got %b/%h expected 1/11", m_valid, m_data); end
        n_cmp++; if (wr_ptr - rd_ptr != 2) begin n_err++; $display("FAIL stall_left: got %0d expected 2", wr_ptr - rd_ptr); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (m_valid !== 1'b1 || m_data !== w[i]) begin n_err++; $display("FAIL stall_drain i=%0d: got %b/%h expected 1/%h", i, m_valid, m_data, w[i]); end
            tick();
        end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL stall_end: got valid %b expected 0", m_valid); end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 10; i++) begin
            m_ready = i[0];
            tick();
            n_cmp++; if (ev_ren !== 1'b0 || m_valid !== 1'b0) begin n_err++; $display("FAIL empty i=%0d: got ren %b valid %b expected 0/0", i, ev_ren, m_valid); end
        end
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        tick();
        tick();
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hA1) begin n_err++; $display("FAIL flush_pre: got %b/%h expected 1/a1", m_valid, m_data); end
        do_flush();
        n_cmp++; if (m_valid !== 1'b0 || rd_count !== 8'd0) begin n_err++; $display("FAIL flush_clear: got %b/%0d expected 0/0", m_valid, rd_count); end
        m_ready = 1'b1;
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale: got valid %b data %h expected 0", m_valid, m_data); end
        tick();
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hC3) begin n_err++; $display("FAIL flush_next: got %b/%h expected 1/c3", m_valid, m_data); end
        tick();
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hD4 || rd_count !== 8'd1) begin n_err++; $display("FAIL flush_next2: got %b/%h/%0d expected 1/d4/1", m_valid, m_data, rd_count); end
        do_flush();
        n_cmp++; if (m_valid !== 1'b0 || rd_count !== 8'd0) begin n_err++; $display("FAIL flush_pop: got %b/%0d expected 0/0", m_valid, rd_count); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        repeat (3) tick();
        m_ready = 1'b1;
        #1;
        n_cmp++; if (fifo_r_en !== 1'b1 || m_data !== 8'hE1) begin n_err++; $display("FAIL rmid_two: got ren %b data %h expected 1/e1", fifo_r_en, m_data); end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (m_valid !== 1'b0 || m_data !== 8'h00 || rd_count !== 8'd0 || fifo_r_en !== 1'b0) begin n_err++; $display("FAIL rmid_reset: got %b/%h/%0d/%b expected 0/00/0/0", m_valid, m_data, rd_count, fifo_r_en); end
        rst = 1'b0;
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got valid %b data %h expected 0", m_valid, m_data); end
        tick();
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hE4) begin n_err++; $display("FAIL rmid_next: got %b/%h expected 1/e4", m_valid, m_data); end
        tick();
    endtask

    task automatic test_count_wrap();
        logic [DW-1:0] w [5];
        int n;
        do_flush();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w[i] = 8'(8'h60 + i);
            push(w[i]);
        end
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
            tick();
            if (ev_pop2) begin
                n_cmp++; if (rd_count2 !== 2'((n + 1) % 4) || ev_data2 !== w[n]) begin n_err++; $display("FAIL wrap n=%0d: got %0d/%h expected %0d/%h", n, rd_count2, ev_data2, (n + 1) % 4, w[n]); end
                n++;
            end
        end
        n_cmp++; if (n != 5) begin n_err++; $display("FAIL wrap_timeout: got %0d pops expected 5", n); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = !rst && ($urandom_range(0, 39) == 0);
            m_ready    = ($urandom_range(0, 2) != 0);
            gate_empty = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) != 0 && (wr_ptr - rd_ptr) < 8) push(8'($urandom));
            tick();
            n_cmp++; if ((ev_ren && ev_empty) || (ev_ren2 && ev_empty)) begin n_err++; $display("FAIL rnd_read_empty cyc=%0d: got ren %b/%b with empty", cyc, ev_ren, ev_ren2); end
            if (ev_pop) begin
                n_cmp++; if (!ev_have_exp || ev_data !== ev_exp) begin n_err++; $display("FAIL rnd_data cyc=%0d: got %h expected %h (have %b)", cyc, ev_data, ev_exp, ev_have_exp); end
            end
            n_cmp++; if (rd_count !== mcount[7:0] || rd_count2 !== mcount[1:0]) begin n_err++; $display("FAIL rnd_count cyc=%0d: got %0d/%0d expected %0d", cyc, rd_count, rd_count2, mcount); end
            if (ev_clr) begin
                n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rnd_clr cyc=%0d: got valid %b expected 0", cyc, m_valid); end
            end else if (ev_valid && !ev_pop) begin
                n_cmp++; if (m_valid !== 1'b1 || m_data !== ev_data) begin n_err++; $display("FAIL rnd_hold cyc=%0d: got %b/%h expected 1/%h", cyc, m_valid, m_data, ev_data); end
            end
        end
        rst = 1'b0; flush = 1'b0; gate_empty = 1'b0; m_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (ev_pop) begin
                n_cmp++; if (!ev_have_exp || ev_data !== ev_exp) begin n_err++; $display("FAIL drain_data cyc=%0d: got %h expected %h", cyc, ev_data, ev_exp); end
            end
        end
        n_cmp++; if (exp_q.size() != 0 || m_valid !== 1'b0) begin n_err++; $display("FAIL drain_left: got %0d words pending, valid %b expected 0/0", exp_q.size(), m_valid); end
    endtask

    initial begin
        wr_ptr = 0;
        mcount = 0;
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_flush();
        test_reset_mid();
        test_count_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO read data and output data.
REQ-002 Parameter COUNT_WIDTH, default 8, width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous clear of buffered and in-flight words.
REQ-006 fifo_empty  input  1  FIFO empty flag; no read may be issued while high.
REQ-007 fifo_r_en  output  1  FIFO read request, one word per asserted cycle.
REQ-008 fifo_rdata  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_en.
REQ-009 m_valid  output  1  output word available.
REQ-010 m_ready  input  1  downstream accepts word.
REQ-011 m_data  output  DATA_WIDTH  output word, registered.
REQ-012 rd_count  output  COUNT_WIDTH  words delivered since reset/flush.

Function
REQ-013 Block SHALL drain a synchronous FIFO (1-cycle read latency) into a valid/ready stream through a 2-entry buffer (head, skid).
REQ-014 pop SHALL be m_valid & m_ready; load SHALL be the registered copy of fifo_r_en (in-flight word arriving this cycle).
REQ-015 fifo_r_en SHALL be !fifo_empty & !flush & !rst & (occupancy + inflight - pop < 2), combinational, pop-aware, for sustained 1 word/cycle.
REQ-016 fifo_r_en SHALL never assert while fifo_empty is high.
REQ-017 fifo_rdata SHALL be captured at the end of the cycle after fifo_r_en; m_valid SHALL rise two cycles after fifo_r_en (latency 2).
REQ-018 FSM states SHALL be EMPTY (occ 0), ONE (occ 1), TWO (occ 2); m_valid = (state != EMPTY); m_data = head.
REQ-019 EMPTY: load -> ONE, head <= fifo_rdata; else stay.
REQ-020 ONE: load & !pop -> TWO, skid <= fifo_rdata; pop & !load -> EMPTY; load & pop -> ONE, head <= fifo_rdata.
REQ-021 TWO: pop & !load -> ONE, head <= skid; load & pop -> TWO, head <= skid, skid <= fifo_rdata; load & !pop SHALL be unreachable.
REQ-022 Word order SHALL be strictly FIFO; no word duplicated or dropped except by flush/rst.
REQ-023 m_data SHALL hold stable while m_valid & !m_ready.
REQ-024 rd_count SHALL increment by 1 on each pop, wrapping modulo 2^COUNT_WIDTH.
REQ-025 flush SHALL, next cycle, force state EMPTY, discard any in-flight word (its load ignored), clear rd_count; fifo_r_en low in flush cycle.
REQ-026 flush and pop in same cycle: flush wins; rd_count = 0.

Reset
REQ-027 On rst: state EMPTY, m_valid 0, m_data 0, skid 0, inflight 0, rd_count 0; fifo_r_en 0 while rst high.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight words; a load arriving the cycle after rst deasserts SHALL be ignored.

Structure
REQ-029 Package fifo_reader_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and constant BUF_DEPTH = 2.
REQ-030 No sub-module; FSM, buffer, in-flight flag and counter in one module.
REQ-031 Implementation SHALL include an assertion that load & !pop in TWO never occurs.

Verification
REQ-032 FIFO holds 0x11,0x22,0x33, m_ready=1 -> fifo_r_en 3 consecutive cycles, m_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after first r_en, rd_count = 3.
REQ-033 FIFO holds 4 words, m_ready=0 -> exactly 2 reads issued, state TWO, m_data 0x11 held; m_ready=1 -> remaining words delivered in order, no gaps.
REQ-034 fifo_empty=1 throughout, m_ready toggling -> fifo_r_en never high, m_valid stays 0.
REQ-035 Word in flight + 1 buffered, assert flush one cycle -> next cycle m_valid=0, rd_count=0, in-flight word not presented; later FIFO words delivered normally.
REQ-036 rst asserted in state TWO with read in flight -> all outputs at reset values next cycle; no stale word appears after rst release.
REQ-037 COUNT_WIDTH=2, deliver 5 words -> rd_count sequence 1,2,3,0,1.
